alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 252 +++++++++++++++++++++++++
 tb/tb_alu_mc.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with a valid/ready handshake on both sides.
//
// Base RISC-V style operations (opcodes 00000-01111), the unused 11xxx range
// and divide special cases finish one edge after capture. The M-extension ops
// (10000-10111) run a radix-2 shift-add multiplier or restoring divider for
// DATA_WIDTH cycles on operand magnitudes. Signs are restored as the FSM
// leaves CALC.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : asynchronous, active-high reset
//   in_valid   : request present
//   in_ready   : block is idle and will capture a request
//   Operation  : operation select (5 bits)
//   SrcA, SrcB : operands
//   PC_Cur     : current PC, zero-extended for JAL/LUI
//   Branch     : selects PC_Cur+4 instead of SrcB for opcode 00011
//   out_valid  : ALUResult holds a finished result
//   out_ready  : consumer takes the result
//   ALUResult  : registered result, held until the next completion

module alu_mc #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5,
  parameter int PC_WIDTH      = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [PC_WIDTH-1:0]      PC_Cur,
  input  logic                     Branch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult
);

  localparam int W   = DATA_WIDTH;
  localparam int SHW = $clog2(W);
  localparam int CW  = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q;
  logic            inReady_q;
  logic            outValid_q;
  logic [W-1:0]    result_q;
  logic [CW-1:0]   cnt_q;
  logic [W:0]      accHi_q;
  logic [W-1:0]    accLo_q;
  logic [W-1:0]    opB_q;
  logic            isMul_q;
  logic [1:0]      mSub_q;
  logic            negQ_q;
  logic            negR_q;

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign ALUResult = result_q;

  // Base ALU, evaluated on the live inputs; only sampled on the capture edge.
  logic [SHW-1:0] shamt;
  logic [W-1:0]   pcPlus4;
  logic [W-1:0]   baseRes;

  assign shamt   = SrcB[SHW-1:0];
  assign pcPlus4 = W'(PC_Cur) + W'(4);

  always_comb begin
    baseRes = '0;
    case (Operation)
      5'b00000: baseRes = SrcA & SrcB;
      5'b00001: baseRes = SrcA | SrcB;
      5'b00010: baseRes = SrcA + SrcB;
      5'b00011: baseRes = Branch ? pcPlus4 : SrcB;
      5'b00100: baseRes = SrcA << shamt;
      5'b00101: baseRes = SrcA >> shamt;
      5'b00110: baseRes = SrcA ^ SrcB;
      5'b00111: baseRes = W'($signed(SrcA) >>> shamt);
      5'b01000: baseRes = W'(SrcA == SrcB);
      5'b01001: baseRes = W'(SrcA != SrcB);
      5'b01010: baseRes = W'(SrcA < SrcB);
      5'b01011: baseRes = W'(SrcA >= SrcB);
      5'b01100: baseRes = W'($signed(SrcA) < $signed(SrcB));
      5'b01111: baseRes = SrcA - SrcB;
      default:  baseRes = '0;
    endcase
  end

  // M-op decode: operand signedness, magnitudes and divide special cases.
  // MUL low half is sign-independent, so it is run unsigned.
  logic         isM;
  logic         isMulOp;
  logic         aSigned;
  logic         bSigned;
  logic         negA;
  logic         negB;
  logic [W-1:0] magA;
  logic [W-1:0] magB;
  logic         divZero;
  logic         divOvf;
  logic [W-1:0] specialRes;

  always_comb begin
    isM        = (Operation[4:3] == 2'b10);
    isMulOp    = isM && !Operation[2];
    aSigned    = 1'b0;
    bSigned    = 1'b0;
    if (isMulOp) begin
      aSigned = (Operation[1:0] == 2'b01) || (Operation[1:0] == 2'b10);
      bSigned = (Operation[1:0] == 2'b01);
    end else begin
      aSigned = !Operation[0];
      bSigned = !Operation[0];
    end
    negA       = aSigned && SrcA[W-1];
    negB       = bSigned && SrcB[W-1];
    magA       = negA ? -SrcA : SrcA;
    magB       = negB ? -SrcB : SrcB;
    divZero    = isM && !isMulOp && (SrcB == '0);
    divOvf     = isM && !isMulOp && !Operation[0] &&
                 (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == '1);
    specialRes = '0;
    if (divZero) begin
      specialRes = Operation[1] ? SrcA : '1;
    end else if (divOvf) begin
      specialRes = Operation[1] ? '0 : SrcA;
    end
  end

  // One radix-2 step. Multiply: conditional add into the high half, then
  // shift the whole {hi,lo} pair right. Divide: shift the next dividend bit
  // into the partial remainder and subtract the divisor if it fits.
  logic [W:0]     mulSum;
  logic [2*W:0]   mulShift;
  logic [W:0]     remSh;
  logic           quotBit;
  logic [W:0]     accHi_d;
  logic [W-1:0]   accLo_d;

  always_comb begin
    mulSum   = '0;
    mulShift = '0;
    remSh    = '0;
    quotBit  = 1'b0;
    accHi_d  = accHi_q;
    accLo_d  = accLo_q;
    if (isMul_q) begin
      mulSum   = accHi_q + (accLo_q[0] ? {1'b0, opB_q} : '0);
      mulShift = {mulSum, accLo_q} >> 1;
      accHi_d  = mulShift[2*W:W];
      accLo_d  = mulShift[W-1:0];
    end else begin
      remSh = {accHi_q[W-1:0], accLo_q[W-1]};
      if (remSh >= {1'b0, opB_q}) begin
        accHi_d = remSh - {1'b0, opB_q};
        quotBit = 1'b1;
      end else begin
        accHi_d = remSh;
      end
      accLo_d = {accLo_q[W-2:0], quotBit};
    end
  end

  // Sign fix-up applied to the values produced by the final step.
  logic [2*W-1:0] prod;
  logic [2*W-1:0] prodS;
  logic [W-1:0]   quot;
  logic [W-1:0]   remd;
  logic [W-1:0]   fixRes;

  always_comb begin
    prod   = {accHi_d[W-1:0], accLo_d};
    prodS  = negQ_q ? -prod : prod;
    quot   = negQ_q ? -accLo_d : accLo_d;
    remd   = negR_q ? -accHi_d[W-1:0] : accHi_d[W-1:0];
    fixRes = '0;
    if (isMul_q) begin
      fixRes = (mSub_q == 2'b00) ? prodS[W-1:0] : prodS[2*W-1:W];
    end else begin
      fixRes = mSub_q[1] ? remd : quot;
    end
  end

  // Control FSM with registered handshake outputs and result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      result_q   <= '0;
      cnt_q      <= '0;
      accHi_q    <= '0;
      accLo_q    <= '0;
      opB_q      <= '0;
      isMul_q    <= 1'b0;
      mSub_q     <= 2'b00;
      negQ_q     <= 1'b0;
      negR_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            inReady_q <= 1'b0;
            if (isM && !divZero && !divOvf) begin
              state_q <= CALC;
              cnt_q   <= '0;
              accHi_q <= '0;
              accLo_q <= magA;
              opB_q   <= magB;
              isMul_q <= isMulOp;
              mSub_q  <= Operation[1:0];
              negQ_q  <= negA ^ negB;
              negR_q  <= negA;
            end else begin
              state_q    <= DONE;
              outValid_q <= 1'b1;
              result_q   <= isM ? specialRes : baseRes;
            end
          end
        end
        CALC: begin
          accHi_q <= accHi_d;
          accLo_q <= accLo_d;
          if (cnt_q == CW'(W - 1)) begin
            state_q    <= DONE;
            outValid_q <= 1'b1;
            result_q   <= fixRes;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q    <= IDLE;
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          inReady_q  <= 1'b1;
          outValid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Testbench for alu_mc. Two instances (32-bit and 16-bit) share one input
// bus; 'sel' chooses which one sees in_valid and whose outputs are checked.
// Expected results come from a wide-integer arithmetic model of the
// operation set.

module tb_alu_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic        outReady;
  logic        branch;
  logic        sel;
  logic [4:0]  operation;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic [8:0]  pcCur;

  logic        inReady32, outValid32, inReady16, outValid16;
  logic [31:0] res32;
  logic [15:0] res16;
  logic        curInReady, curOutValid;
  logic [31:0] curRes;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign curInReady  = sel ? inReady16  : inReady32;
  assign curOutValid = sel ? outValid16 : outValid32;
  assign curRes      = sel ? {16'h0, res16} : res32;

  alu_mc #(.DATA_WIDTH(32), .OPCODE_LENGTH(5), .PC_WIDTH(9)) dut32 (
    .clk(clk), .reset(reset), .in_valid(inValid & ~sel), .in_ready(inReady32),
    .Operation(operation), .SrcA(srcA), .SrcB(srcB), .PC_Cur(pcCur),
    .Branch(branch), .out_valid(outValid32), .out_ready(outReady),
    .ALUResult(res32)
  );

  alu_mc #(.DATA_WIDTH(16), .OPCODE_LENGTH(5), .PC_WIDTH(9)) dut16 (
    .clk(clk), .reset(reset), .in_valid(inValid & sel), .in_ready(inReady16),
    .Operation(operation), .SrcA(srcA[15:0]), .SrcB(srcB[15:0]), .PC_Cur(pcCur),
    .Branch(branch), .out_valid(outValid16), .out_ready(outReady),
    .ALUResult(res16)
  );

  // Count one comparison and report it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result computed with 128-bit integer arithmetic at width w.
  function automatic logic [31:0] refModel(input int w, input logic [4:0] op,
                                           input logic [31:0] aIn,
                                           input logic [31:0] bIn,
                                           input logic [8:0] pc,
                                           input logic br);
    logic [127:0]        one, full, mask, a, b;
    logic signed [127:0] sa, sb, r;
    int                  sh;
    logic                ovf;
    one  = 128'd1;
    full = one << w;
    mask = full - 1;
    a    = aIn & mask;
    b    = bIn & mask;
    sa   = a[w-1] ? $signed(a - full) : $signed(a);
    sb   = b[w-1] ? $signed(b - full) : $signed(b);
    sh   = int'(b[4:0]) & (w - 1);
    ovf  = (sa == -$signed(full >> 1)) && (sb == -1);
    case (op)
      5'd0:  r = a & b;
      5'd1:  r = a | b;
      5'd2:  r = a + b;
      5'd3:  r = br ? pc + 4 : b;
      5'd4:  r = a << sh;
      5'd5:  r = a >> sh;
      5'd6:  r = a ^ b;
      5'd7:  r = sa >>> sh;
      5'd8:  r = (a == b);
      5'd9:  r = (a != b);
      5'd10: r = (a < b);
      5'd11: r = (a >= b);
      5'd12: r = (sa < sb);
      5'd15: r = a - b;
      5'd16: r = a * b;
      5'd17: r = (sa * sb) >>> w;
      5'd18: r = (sa * $signed(b)) >>> w;
      5'd19: r = (a * b) >> w;
      5'd20: r = (b == 0) ? $signed(mask) : (ovf ? sa : sa / sb);
      5'd21: r = (b == 0) ? mask : a / b;
      5'd22: r = (b == 0) ? sa : (ovf ? 0 : sa % sb);
      5'd23: r = (b == 0) ? a : a % b;
      default: r = 0;
    endcase
    return 32'(r & mask);
  endfunction

  // Edges from the capture edge (counted as 1) to out_valid.
  function automatic int refLatency(input int w, input logic [4:0] op,
                                    input logic [31:0] aIn, input logic [31:0] bIn);
    logic [31:0] mask, a, b, minv;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
    a    = aIn & mask;
    b    = bIn & mask;
    minv = 32'd1 << (w - 1);
    if (op >= 5'd16 && op <= 5'd19) return w + 1;
    if (op >= 5'd20 && op <= 5'd23) begin
      if (b == 0) return 1;
      if ((op == 5'd20 || op == 5'd22) && a == minv && b == mask) return 1;
      return w + 1;
    end
    return 1;
  endfunction

  // One full transaction: capture, wait with garbage on the inputs, check,
  // hold out_ready low for 'hold' cycles, then release.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [8:0] pc,
                               input logic br, input int hold, input string tag);
    int          w, lat, expLat;
    logic [31:0] exp;
    bit          got;
    w      = sel ? 16 : 32;
    exp    = refModel(w, op, a, b, pc, br);
    expLat = refLatency(w, op, a, b);
    @(negedge clk);
    checkOutput({tag, "/in_ready"}, curInReady, 1);
    operation = op; srcA = a; srcB = b; pcCur = pc; branch = br;
    inValid = 1'b1; outReady = 1'b0;
    @(posedge clk); #1;
    lat = 1;
    got = curOutValid;
    while (!got && lat < 100) begin
      inValid   = 1'($urandom_range(0, 1));
      operation = 5'($urandom);
      srcA      = $urandom;
      srcB      = $urandom;
      pcCur     = 9'($urandom);
      branch    = 1'($urandom);
      @(posedge clk); #1;
      lat++;
      got = curOutValid;
    end
    inValid = 1'b0;
    checkOutput({tag, "/out_valid"}, got, 1);
    if (got) begin
      checkOutput({tag, "/latency"}, lat, expLat);
      checkOutput({tag, "/result"}, curRes, exp);
      if (hold > 0) begin
        repeat (hold) @(posedge clk);
        #1;
        checkOutput({tag, "/hold_valid"}, curOutValid, 1);
        checkOutput({tag, "/hold_ready"}, curInReady, 0);
        checkOutput({tag, "/hold_result"}, curRes, exp);
      end
      @(negedge clk);
      outReady = 1'b1;
      @(posedge clk); #1;
      outReady = 1'b0;
      checkOutput({tag, "/release_valid"}, curOutValid, 0);
      checkOutput({tag, "/release_ready"}, curInReady, 1);
      checkOutput({tag, "/idle_result"}, curRes, exp);
    end
  endtask

  // Start a long divide, reset it after 10 iterations, make sure it vanishes.
  task automatic applyResetMidCalc();
    int seen;
    @(negedge clk);
    operation = 5'b10101; srcA = 32'd1000; srcB = 32'd7; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("rst_calc/out_valid", outValid32, 0);
    checkOutput("rst_calc/in_ready", inReady32, 1);
    checkOutput("rst_calc/result", res32, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (outValid32) seen++;
    end
    checkOutput("rst_calc/no_valid", seen, 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [4:0]  op;
    logic [31:0] a, b;
    reset = 1'b1; inValid = 1'b0; outReady = 1'b0; sel = 1'b0;
    operation = '0; srcA = '0; srcB = '0; pcCur = '0; branch = 1'b0;
    #12;
    checkOutput("reset/in_ready32", inReady32, 1);
    checkOutput("reset/out_valid32", outValid32, 0);
    checkOutput("reset/result32", res32, 0);
    checkOutput("reset/in_ready16", inReady16, 1);
    checkOutput("reset/out_valid16", outValid16, 0);
    checkOutput("reset/result16", res16, 0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(5'b00010, 32'd7, 32'hFFFF_FFFD, 9'd0, 1'b0, 0, "add");
    applyStimulus(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9'd0, 1'b0, 0, "mulhu");
    applyStimulus(5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9'd0, 1'b0, 0, "mul");
    applyStimulus(5'b10100, 32'hFFFF_FFF9, 32'd2, 9'd0, 1'b0, 0, "div_neg");
    applyStimulus(5'b10110, 32'hFFFF_FFF9, 32'd2, 9'd0, 1'b0, 0, "rem_neg");
    applyStimulus(5'b10101, 32'd100, 32'd0, 9'd0, 1'b0, 0, "divu_zero");
    applyStimulus(5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 9'd0, 1'b0, 0, "div_ovf");
    applyStimulus(5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 9'd0, 1'b0, 0, "rem_ovf");
    applyStimulus(5'b10101, 32'd1000, 32'd7, 9'd0, 1'b0, 5, "divu_hold");
    applyStimulus(5'b00011, 32'd5, 32'h0000_1234, 9'h1FC, 1'b1, 0, "jal_pc");
    applyStimulus(5'b00011, 32'd5, 32'h0000_1234, 9'h1FC, 1'b0, 0, "lui_srcb");
    applyResetMidCalc();
    applyStimulus(5'b01111, 32'd5, 32'd9, 9'd0, 1'b0, 0, "sub_after_rst");

    for (int i = 0; i < 40; i++) begin
      op = 5'($urandom_range(0, 31));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      applyStimulus(op, a, b, 9'($urandom), 1'($urandom), $urandom_range(0, 2), "rand32");
    end

    @(negedge clk);
    sel = 1'b1;
    applyStimulus(5'b10000, 32'h0100, 32'h0100, 9'd0, 1'b0, 0, "mul16");
    applyStimulus(5'b10001, 32'h0100, 32'h0100, 9'd0, 1'b0, 0, "mulh16");
    for (int i = 0; i < 20; i++) begin
      op = 5'($urandom_range(0, 31));
      a  = ($urandom_range(0, 7) == 0) ? 32'h0000_8000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'h0000_FFFF;
        default: b = $urandom;
      endcase
      applyStimulus(op, a, b, 9'($urandom), 1'($urandom), $urandom_range(0, 1), "rand16");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
